sdram_req_arbiter: RTL and testbench
====================================

SDRAM_REQ_ARBITER -- requirements
Module: sdram_req_arbiter

Interface
REQ-001 SHALL have parameter REFRESH_PERIOD, default 780, clk cycles between refresh requests.
REQ-002 SHALL have parameter ADDR_W, default 22, requester address width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_bar  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port a_req / b_req  input  1 each  requester A/B transaction request, held until grant.
REQ-006 SHALL have port a_write / b_write  input  1 each  1 = write, 0 = read.
REQ-007 SHALL have port a_addr / b_addr  input  ADDR_W each  transaction start address.
REQ-008 SHALL have port a_burst / b_burst  input  4 each  burst length code.
REQ-009 SHALL have port a_gnt / b_gnt  output  1 each  one-cycle grant pulse; request fields are sampled on this cycle.
REQ-010 SHALL have port a_done / b_done  output  1 each  one-cycle completion pulse to the owner.
REQ-011 SHALL have port ctl_start  output  1  one-cycle command strobe to the SDRAM control unit.
REQ-012 SHALL have ports ctl_write (1), ctl_addr (ADDR_W), ctl_burst (4), ctl_refresh (1)  output  registered command fields, stable from ctl_start until ctl_done.
REQ-013 SHALL have port ctl_done  input  1  one-cycle completion pulse from the control unit.
REQ-014 SHALL have port ref_overflow  output  1  sticky flag: a refresh interval expired while a refresh was still pending.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, REFRESH.
REQ-016 IDLE: if ref_pending, go to REFRESH; else if any req, pick a winner, pulse its gnt, latch its fields into ctl_*, and go to ISSUE; else stay.
REQ-017 Arbitration SHALL be round-robin: last_owner toggles on each grant; on simultaneous a_req and b_req the non-last_owner wins; after reset last_owner = B, so A wins the first tie.
REQ-018 ISSUE SHALL assert ctl_start for exactly one cycle (ctl_refresh = 0), then go to WAIT.
REQ-019 WAIT SHALL hold until ctl_done = 1, then pulse done to the owner in the same cycle and go to IDLE.
REQ-020 REFRESH: on entry cycle ctl_start = 1 and ctl_refresh = 1, clear ref_pending; then hold until ctl_done, then go to IDLE; no a_done/b_done pulse.
REQ-021 Grant latency SHALL be 1 cycle from req seen in IDLE; ctl_start SHALL follow gnt by exactly 1 cycle.
REQ-022 Refresh counter SHALL be a down-counter of width clog2(REFRESH_PERIOD), loaded with REFRESH_PERIOD-1. At 0 it reloads and sets ref_pending; it runs in every state.
REQ-023 If the counter expires while ref_pending = 1, ref_pending SHALL stay 1 and ref_overflow SHALL set; ref_overflow clears only on reset.
REQ-024 Refresh SHALL take priority over requesters only at IDLE and never preempts a transaction in WAIT.
REQ-025 ctl_done outside WAIT/REFRESH SHALL be ignored.
REQ-026 gnt SHALL never be asserted to both requesters in one cycle; at most one of gnt, ctl_start, done is active per requester per cycle.

Reset
REQ-027 While reset_bar = 0: state = IDLE; all gnt/done/ctl_start/ctl_refresh/ctl_write = 0; ctl_addr/ctl_burst = 0; ref_pending = 0; ref_overflow = 0; counter = REFRESH_PERIOD-1; last_owner = B.
REQ-028 Reset asserted mid-transaction SHALL abandon it with no done pulse; the first grant after release is possible 1 cycle after reset_bar rises.

Structure
REQ-029 FSM state encoding and the requester-ID constants (A = 0, B = 1) SHALL live in the shared SDRAM package.
REQ-030 The refresh down-counter SHALL be the single sub-module sdram_refresh_timer (outputs expire pulse).

Verification
REQ-031 Single A write, addr 0x00010, burst 4 -> a_gnt at cycle 1, ctl_start/ctl_write = 1/ctl_addr = 0x00010 at cycle 2; ctl_done at cycle 6 -> a_done at cycle 6, IDLE at cycle 7.
REQ-032 a_req and b_req held continuously, 4 transactions -> grants A, B, A, B.
REQ-033 REFRESH_PERIOD = 20, no traffic -> ctl_start with ctl_refresh = 1 roughly every 20 cycles; first at cycle 21 after reset release.
REQ-034 REFRESH_PERIOD = 20, hold ctl_done low for 45 cycles during a B read -> ref_overflow = 1; after B done, refresh is issued before a pending a_req.
REQ-035 Reset_bar pulsed low in WAIT -> all outputs 0 immediately, no b_done; a fresh a_req is granted 1 cycle after release.

Source files
------------

// File: rtl/sdram_req_arbiter_pkg.sv
// Shared SDRAM arbiter definitions: FSM state encoding, requester IDs and
// the round-robin winner selection.
package sdram_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_REFRESH = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    // On a tie the requester that did not own the last transaction wins.
    function automatic req_id_t pick_winner(input logic a_req,
                                            input logic b_req,
                                            input req_id_t last_owner);
        if (a_req && b_req)
            return (last_owner == REQ_A) ? REQ_B : REQ_A;
        else if (a_req)
            return REQ_A;
        else
            return REQ_B;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval down-counter; expire is high for the one
// cycle the count sits at zero, after which it reloads. PERIOD must be >= 2.
module sdram_refresh_timer #(
    parameter int unsigned PERIOD = 780
) (
    input  logic clk,
    input  logic reset_bar,
    output logic expire
);

    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar)
            cnt <= RELOAD;
        else if (cnt == '0)
            cnt <= RELOAD;
        else
            cnt <= cnt - 1'b1;
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/sdram_req_arbiter.sv
// Two-requester round-robin arbiter in front of the SDRAM control unit,
// inserting periodic refresh commands between transactions.
module sdram_req_arbiter
    import sdram_req_arbiter_pkg::*;
#(
    parameter int unsigned REFRESH_PERIOD = 780,
    parameter int unsigned ADDR_W         = 22
) (
    input  logic              clk,
    input  logic              reset_bar,
    input  logic              a_req,
    input  logic              a_write,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [3:0]        a_burst,
    input  logic              b_req,
    input  logic              b_write,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [3:0]        b_burst,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_done,
    output logic              b_done,
    output logic              ctl_start,
    output logic              ctl_write,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [3:0]        ctl_burst,
    output logic              ctl_refresh,
    input  logic              ctl_done,
    output logic              ref_overflow
);

    arb_state_t state, state_nxt;
    req_id_t    last_owner, winner;
    logic       grant, ref_start, ref_clear;
    logic       ref_pending, ref_expire;

    sdram_refresh_timer #(
        .PERIOD(REFRESH_PERIOD)
    ) u_refresh_timer (
        .clk      (clk),
        .reset_bar(reset_bar),
        .expire   (ref_expire)
    );

    // ctl_start is high exactly on the first cycle of ISSUE or REFRESH.
    assign ref_clear = (state == ST_REFRESH) && ctl_start;

    always_comb begin
        state_nxt = state;
        winner    = last_owner;
        grant     = 1'b0;
        ref_start = 1'b0;
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        a_done    = 1'b0;
        b_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ref_pending) begin
                    ref_start = 1'b1;
                    state_nxt = ST_REFRESH;
                end else if (reset_bar && (a_req || b_req)) begin
                    // reset_bar gate keeps the combinational grant quiet while held in reset
                    winner    = pick_winner(a_req, b_req, last_owner);
                    grant     = 1'b1;
                    a_gnt     = (winner == REQ_A);
                    b_gnt     = (winner == REQ_B);
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (ctl_done) begin
                    a_done    = (last_owner == REQ_A);
                    b_done    = (last_owner == REQ_B);
                    state_nxt = ST_IDLE;
                end
            end
            ST_REFRESH: begin
                if (ctl_done && !ctl_start)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state       <= ST_IDLE;
            last_owner  <= REQ_B;
            ctl_start   <= 1'b0;
            ctl_write   <= 1'b0;
            ctl_refresh <= 1'b0;
            ctl_addr    <= '0;
            ctl_burst   <= '0;
        end else begin
            state     <= state_nxt;
            ctl_start <= grant || ref_start;
            if (grant) begin
                last_owner  <= winner;
                ctl_refresh <= 1'b0;
                if (winner == REQ_A) begin
                    ctl_write <= a_write;
                    ctl_addr  <= a_addr;
                    ctl_burst <= a_burst;
                end else begin
                    ctl_write <= b_write;
                    ctl_addr  <= b_addr;
                    ctl_burst <= b_burst;
                end
            end else if (ref_start) begin
                ctl_refresh <= 1'b1;
                ctl_write   <= 1'b0;
            end
        end
    end

    // A new interval landing on the cycle the old one is served is not an overflow.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            ref_pending  <= 1'b0;
            ref_overflow <= 1'b0;
        end else begin
            if (ref_expire)
                ref_pending <= 1'b1;
            else if (ref_clear)
                ref_pending <= 1'b0;
            if (ref_expire && ref_pending && !ref_clear)
                ref_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Scoreboard bench for sdram_req_arbiter: directed scenarios push expected
// events with their cycle number; a negedge monitor pops and compares.
module tb_sdram_req_arbiter;

    localparam int unsigned AW = 22;
    localparam int EV_AGNT  = 0;
    localparam int EV_BGNT  = 1;
    localparam int EV_START = 2;
    localparam int EV_ADONE = 3;
    localparam int EV_BDONE = 4;

    typedef struct {
        int          kind;
        int          cyc;
        logic        w;
        logic [AW-1:0] addr;
        logic [3:0]  burst;
        logic        rf;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset_bar = 1'b0;
    logic          a_req = 1'b0, b_req = 1'b0;
    logic          a_write = 1'b0, b_write = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [3:0]    a_burst = '0, b_burst = '0;
    logic          ctl_done = 1'b0;
    logic          a_gnt, b_gnt, a_done, b_done;
    logic          ctl_start, ctl_write, ctl_refresh, ref_overflow;
    logic [AW-1:0] ctl_addr;
    logic [3:0]    ctl_burst;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    sdram_req_arbiter #(
        .REFRESH_PERIOD(20),
        .ADDR_W        (AW)
    ) dut (
        .clk         (clk),
        .reset_bar   (reset_bar),
        .a_req       (a_req),
        .a_write     (a_write),
        .a_addr      (a_addr),
        .a_burst     (a_burst),
        .b_req       (b_req),
        .b_write     (b_write),
        .b_addr      (b_addr),
        .b_burst     (b_burst),
        .a_gnt       (a_gnt),
        .b_gnt       (b_gnt),
        .a_done      (a_done),
        .b_done      (b_done),
        .ctl_start   (ctl_start),
        .ctl_write   (ctl_write),
        .ctl_addr    (ctl_addr),
        .ctl_burst   (ctl_burst),
        .ctl_refresh (ctl_refresh),
        .ctl_done    (ctl_done),
        .ref_overflow(ref_overflow)
    );

    always #5 clk = ~clk;

    // Cycle k is the interval following the k-th rising edge after reset release.
    always @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    function automatic string ev_name(input int k);
        case (k)
            EV_AGNT:  return "a_gnt";
            EV_BGNT:  return "b_gnt";
            EV_START: return "ctl_start";
            EV_ADONE: return "a_done";
            default:  return "b_done";
        endcase
    endfunction

    task automatic push_ev(input int kind, input int c);
        ev_t e;
        e.kind = kind; e.cyc = c; e.w = 1'b0; e.addr = '0; e.burst = '0; e.rf = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_cmd(input int c, input logic w, input logic [AW-1:0] addr,
                            input logic [3:0] burst, input logic rf);
        ev_t e;
        e.kind = EV_START; e.cyc = c; e.w = w; e.addr = addr; e.burst = burst; e.rf = rf;
        exp_q.push_back(e);
    endtask

    task automatic sb_match(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got %s at cycle %0d, required no event", ev_name(kind), cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc) begin
            errors++;
            $display("FAIL sb_event: got %s@%0d, required %s@%0d",
                     ev_name(kind), cyc, ev_name(e.kind), e.cyc);
        end else if (kind == EV_START &&
                     (ctl_refresh !== e.rf || ctl_write !== e.w ||
                      (!e.rf && (ctl_addr !== e.addr || ctl_burst !== e.burst)))) begin
            errors++;
            $display("FAIL sb_cmd@%0d: got rf=%0b w=%0b addr=%0h burst=%0h, required rf=%0b w=%0b addr=%0h burst=%0h",
                     cyc, ctl_refresh, ctl_write, ctl_addr, ctl_burst, e.rf, e.w, e.addr, e.burst);
        end
    endtask

    always @(negedge clk) begin
        if (reset_bar) begin
            if (a_gnt)     sb_match(EV_AGNT);
            if (b_gnt)     sb_match(EV_BGNT);
            if (ctl_start) sb_match(EV_START);
            if (a_done)    sb_match(EV_ADONE);
            if (b_done)    sb_match(EV_BDONE);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a_gnt"},        32'(a_gnt),        0);
        chk({tag, "_b_gnt"},        32'(b_gnt),        0);
        chk({tag, "_a_done"},       32'(a_done),       0);
        chk({tag, "_b_done"},       32'(b_done),       0);
        chk({tag, "_ctl_start"},    32'(ctl_start),    0);
        chk({tag, "_ctl_write"},    32'(ctl_write),    0);
        chk({tag, "_ctl_refresh"},  32'(ctl_refresh),  0);
        chk({tag, "_ctl_addr"},     32'(ctl_addr),     0);
        chk({tag, "_ctl_burst"},    32'(ctl_burst),    0);
        chk({tag, "_ref_overflow"}, 32'(ref_overflow), 0);
    endtask

    task automatic goto_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Requests and ctl_done are driven high during reset to show nothing leaks out.
    task automatic do_reset(input string tag, input bit immediate);
        reset_bar = 1'b0;
        a_req = 1'b1; b_req = 1'b1; ctl_done = 1'b1;
        #1;
        if (immediate) check_zero({tag, "_imm"});
        repeat (3) @(posedge clk);
        #1;
        check_zero(tag);
        a_req = 1'b0; b_req = 1'b0; ctl_done = 1'b0;
        a_write = 1'b0; b_write = 1'b0; a_addr = '0; b_addr = '0; a_burst = '0; b_burst = '0;
        @(negedge clk);
        #2;
        reset_bar = 1'b1;
    endtask

    task automatic drain(input string tag, input int k);
        goto_cyc(k);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d events never seen (next %s@%0d), required 0",
                     tag, exp_q.size(), ev_name(exp_q[0].kind), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic pulse_done(input int k);
        goto_cyc(k);
        ctl_done = 1'b1;
        goto_cyc(k + 1);
        ctl_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        // Single A write, then a B read with ctl_done strobes outside WAIT.
        do_reset("rst0", 1'b0);
        goto_cyc(1);
        a_req = 1'b1; a_write = 1'b1; a_addr = 22'h00010; a_burst = 4'd4;
        push_ev(EV_AGNT, 1);
        push_cmd(2, 1'b1, 22'h00010, 4'd4, 1'b0);
        goto_cyc(2);
        a_req = 1'b0;
        goto_cyc(6);
        push_ev(EV_ADONE, 6);
        pulse_done(6);
        b_req = 1'b1; b_write = 1'b0; b_addr = 22'h20000; b_burst = 4'd8;
        push_ev(EV_BGNT, 7);
        push_cmd(8, 1'b0, 22'h20000, 4'd8, 1'b0);
        goto_cyc(8);
        b_req = 1'b0;
        pulse_done(8);
        goto_cyc(10);
        push_ev(EV_BDONE, 10);
        pulse_done(10);
        pulse_done(12);
        drain("s1", 16);

        // Both requesters held: A, B, A, B.
        do_reset("rst1", 1'b0);
        goto_cyc(1);
        a_req = 1'b1; a_write = 1'b1; a_addr = 22'h00100; a_burst = 4'd1;
        b_req = 1'b1; b_write = 1'b0; b_addr = 22'h00200; b_burst = 4'd2;
        push_ev(EV_AGNT, 1);
        push_cmd(2, 1'b1, 22'h00100, 4'd1, 1'b0);
        goto_cyc(4);
        push_ev(EV_ADONE, 4);
        push_ev(EV_BGNT, 5);
        push_cmd(6, 1'b0, 22'h00200, 4'd2, 1'b0);
        pulse_done(4);
        goto_cyc(8);
        push_ev(EV_BDONE, 8);
        push_ev(EV_AGNT, 9);
        push_cmd(10, 1'b1, 22'h00100, 4'd1, 1'b0);
        pulse_done(8);
        goto_cyc(12);
        push_ev(EV_ADONE, 12);
        push_ev(EV_BGNT, 13);
        push_cmd(14, 1'b0, 22'h00200, 4'd2, 1'b0);
        pulse_done(12);
        goto_cyc(14);
        a_req = 1'b0; b_req = 1'b0;
        goto_cyc(16);
        push_ev(EV_BDONE, 16);
        pulse_done(16);
        drain("s2", 19);

        // Idle refresh cadence.
        do_reset("rst2", 1'b0);
        for (int i = 0; i < 3; i++) begin
            push_cmd(21 + 20 * i, 1'b0, '0, '0, 1'b1);
            pulse_done(23 + 20 * i);
        end
        goto_cyc(64);
        chk("s3_overflow", 32'(ref_overflow), 0);
        drain("s3", 66);

        // Long B read at max address, refresh overflow, refresh ahead of waiting A.
        do_reset("rst3", 1'b0);
        goto_cyc(1);
        b_req = 1'b1; b_write = 1'b0; b_addr = 22'h3FFFFF; b_burst = 4'hF;
        push_ev(EV_BGNT, 1);
        push_cmd(2, 1'b0, 22'h3FFFFF, 4'hF, 1'b0);
        goto_cyc(2);
        b_req = 1'b0;
        goto_cyc(30);
        a_req = 1'b1; a_write = 1'b1; a_addr = 22'h00005; a_burst = 4'd2;
        goto_cyc(38);
        chk("s4_overflow_before", 32'(ref_overflow), 0);
        goto_cyc(41);
        chk("s4_overflow_set", 32'(ref_overflow), 1);
        goto_cyc(48);
        push_ev(EV_BDONE, 48);
        push_cmd(50, 1'b0, '0, '0, 1'b1);
        push_ev(EV_AGNT, 53);
        push_cmd(54, 1'b1, 22'h00005, 4'd2, 1'b0);
        pulse_done(48);
        pulse_done(52);
        goto_cyc(54);
        a_req = 1'b0;
        goto_cyc(56);
        push_ev(EV_ADONE, 56);
        push_cmd(61, 1'b0, '0, '0, 1'b1);
        pulse_done(56);
        pulse_done(63);
        goto_cyc(64);
        chk("s4_overflow_sticky", 32'(ref_overflow), 1);
        drain("s4", 66);

        // Reset mid-WAIT abandons the B read; a fresh A request follows.
        do_reset("rst4", 1'b0);
        goto_cyc(1);
        b_req = 1'b1; b_write = 1'b0; b_addr = 22'h00040; b_burst = 4'd3;
        push_ev(EV_BGNT, 1);
        push_cmd(2, 1'b0, 22'h00040, 4'd3, 1'b0);
        goto_cyc(2);
        b_req = 1'b0;
        goto_cyc(5);
        do_reset("rst_wait", 1'b1);
        goto_cyc(1);
        a_req = 1'b1; a_write = 1'b0; a_addr = 22'h00123; a_burst = 4'd1;
        push_ev(EV_AGNT, 1);
        push_cmd(2, 1'b0, 22'h00123, 4'd1, 1'b0);
        goto_cyc(2);
        a_req = 1'b0;
        goto_cyc(4);
        push_ev(EV_ADONE, 4);
        pulse_done(4);
        drain("s5", 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
